// File: rtl/bpred_pkg.sv
// Shared types and helpers for the bimodal predictor update path.
package bpred_pkg;

  localparam int CTR_W = 2;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bpred_state_e;

  // 2-bit saturating counter step toward the resolved direction.
  function automatic logic [CTR_W-1:0] sat_ctr_update(input logic [CTR_W-1:0] old,
                                                      input logic             dir);
    logic [CTR_W-1:0] r;
    r = old;
    if (dir) begin
      if (old != '1) r = old + CTR_W'(1);
    end else begin
      if (old != '0) r = old - CTR_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/bpred_upd_fifo.sv
// Small synchronous FIFO buffering pending counter-table writes.
module bpred_upd_fifo #(
  parameter  int W     = 14,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/bpred_update_sched.sv
// Owns the bimodal table write port: reset sweep, then buffered counter updates.
module bpred_update_sched
  import bpred_pkg::*;
#(
  parameter  int         IDX_W      = 12,
  parameter  int         FIFO_DEPTH = 4,
  parameter  logic [1:0] INIT_CTR   = 2'b01,
  localparam int         CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_valid,
  input  logic [IDX_W-1:0] up_index,
  input  logic [1:0]       up_old_ctr,
  input  logic             up_dir,
  output logic             up_ready,
  input  logic             stall,
  output logic             mem_wren,
  output logic [IDX_W-1:0] mem_wraddr,
  output logic [1:0]       mem_wdata,
  output logic             init_busy,
  output logic [CNT_W-1:0] pending,
  output logic [7:0]       drop_cnt
);

  localparam int EW = IDX_W + CTR_W;

  bpred_state_e     state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             wren_q, wren_d;
  logic [IDX_W-1:0] wraddr_q, wraddr_d;
  logic [1:0]       wdata_q, wdata_d;
  logic [7:0]       drop_q, drop_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EW-1:0] fifo_wdata, fifo_rdata;

  assign init_busy  = (state_q == ST_INIT);
  // Registered full only: a full FIFO refuses even on a popping cycle.
  assign up_ready   = (state_q == ST_RUN) & ~fifo_full;
  assign fifo_push  = up_valid & up_ready;
  assign fifo_wdata = {up_index, sat_ctr_update(up_old_ctr, up_dir)};

  assign mem_wren   = wren_q;
  assign mem_wraddr = wraddr_q;
  assign mem_wdata  = wdata_q;
  assign drop_cnt   = drop_q;

  bpred_upd_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending)
  );

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    wren_d   = 1'b0;
    wraddr_d = wraddr_q;
    wdata_d  = wdata_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_INIT: begin
        wren_d   = 1'b1;
        wraddr_d = sweep_q;
        wdata_d  = INIT_CTR;
        sweep_d  = sweep_q + IDX_W'(1);
        if (sweep_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!fifo_empty && !stall) begin
          fifo_pop              = 1'b1;
          wren_d                = 1'b1;
          {wraddr_d, wdata_d}   = fifo_rdata;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (up_valid && !up_ready && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_INIT;
      sweep_q  <= '0;
      wren_q   <= 1'b0;
      wraddr_q <= '0;
      wdata_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      wdata_q  <= wdata_d;
      drop_q   <= drop_d;
    end
  end

endmodule

// File: tb/tb_bpred_update_sched.sv
// Randomized bench for bpred_update_sched against a queue-based reference model.
module tb_bpred_update_sched;

  localparam int IDX_W = 4;
  localparam int DEPTH = 4;
  localparam int NENT  = 1 << IDX_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             up_valid;
  logic [IDX_W-1:0] up_index;
  logic [1:0]       up_old_ctr;
  logic             up_dir;
  logic             up_ready;
  logic             stall;
  logic             mem_wren;
  logic [IDX_W-1:0] mem_wraddr;
  logic [1:0]       mem_wdata;
  logic             init_busy;
  logic [CNT_W-1:0] pending;
  logic [7:0]       drop_cnt;

  bpred_update_sched #(
    .IDX_W      (IDX_W),
    .FIFO_DEPTH (DEPTH),
    .INIT_CTR   (2'b01)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .up_valid   (up_valid),
    .up_index   (up_index),
    .up_old_ctr (up_old_ctr),
    .up_dir     (up_dir),
    .up_ready   (up_ready),
    .stall      (stall),
    .mem_wren   (mem_wren),
    .mem_wraddr (mem_wraddr),
    .mem_wdata  (mem_wdata),
    .init_busy  (init_busy),
    .pending    (pending),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Table image built from what the DUT actually writes.
  logic [1:0] tbl [NENT];
  always @(posedge clk) if (mem_wren) tbl[mem_wraddr] <= mem_wdata;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: request-level view of the scheduler.
  bit         m_run;
  int         m_sweep;
  int         m_q[$];
  bit         m_wren;
  int         m_addr, m_data, m_drop;
  int         ref_tbl [NENT];

  function automatic int ref_ctr(input int old, input bit dir);
    int v;
    v = dir ? old + 1 : old - 1;
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return v;
  endfunction

  task automatic model_reset();
    m_run = 0; m_sweep = 0; m_q.delete();
    m_wren = 0; m_addr = 0; m_data = 0; m_drop = 0;
    for (int i = 0; i < NENT; i++) ref_tbl[i] = 1;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ".wren"},  32'(mem_wren),   32'(m_wren));
    chk({ph, ".addr"},  32'(mem_wraddr), m_addr);
    chk({ph, ".data"},  32'(mem_wdata),  m_data);
    chk({ph, ".pend"},  32'(pending),    m_q.size());
    chk({ph, ".busy"},  32'(init_busy),  32'(!m_run));
    chk({ph, ".ready"}, 32'(up_ready),   32'(m_run && m_q.size() < DEPTH));
    chk({ph, ".drop"},  32'(drop_cnt),   m_drop);
  endtask

  // One clock: model sees the inputs held across the edge, outputs checked 1ns later.
  task automatic step(input string ph);
    bit rdy, popn, acc;
    int ent_idx, ent_ctr, e;
    rdy     = m_run && m_q.size() < DEPTH;
    popn    = m_run && m_q.size() > 0 && !stall;
    acc     = up_valid && rdy;
    ent_idx = int'(up_index);
    ent_ctr = ref_ctr(int'(up_old_ctr), up_dir);
    @(posedge clk); #1;
    if (!m_run) begin
      m_wren = 1; m_addr = m_sweep; m_data = 1;
      m_sweep++;
      if (m_sweep == NENT) begin m_run = 1; m_sweep = 0; end
    end else begin
      if (popn) begin
        e = m_q.pop_front();
        m_wren = 1; m_addr = e / 4; m_data = e % 4;
      end else m_wren = 0;
      if (acc) begin
        m_q.push_back(ent_idx * 4 + ent_ctr);
        ref_tbl[ent_idx] = ent_ctr;
      end
    end
    if (up_valid && !rdy && m_drop < 255) m_drop++;
    check_outputs(ph);
  endtask

  task automatic set_req(input bit v, input int idx, input int old, input bit dir);
    up_valid   = v;
    up_index   = IDX_W'(idx);
    up_old_ctr = 2'(old);
    up_dir     = dir;
  endtask

  task automatic rand_req(input bit v);
    set_req(v, $urandom_range(0, NENT-1), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
  endtask

  task automatic check_table(input string ph);
    for (int i = 0; i < NENT; i++) chk({ph, ".tbl"}, 32'(tbl[i]), ref_tbl[i]);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    set_req(0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst");
    reset = 1'b0;

    // Sweep with three requests arriving mid-sweep; all must be dropped.
    for (int k = 0; k < 20; k++) begin
      if (k == 4 || k == 6 || k == 8) rand_req(1); else set_req(0, 0, 0, 0);
      step("sweep");
    end
    chk("sweep.drop3", 32'(drop_cnt), 3);
    check_table("sweep");

    // Saturation arithmetic, back-to-back.
    set_req(1, 5, 3, 1); step("sat");
    set_req(1, 6, 0, 0); step("sat");
    set_req(1, 7, 1, 1); step("sat");
    set_req(0, 0, 0, 0);
    repeat (4) step("sat");

    // Backpressure: six requests against a stalled FIFO of four.
    stall = 1'b1;
    for (int k = 0; k < 6; k++) begin rand_req(1); step("bp"); end
    chk("bp.full", 32'(pending), DEPTH);
    set_req(0, 0, 0, 0); stall = 1'b0;
    repeat (6) step("bp");

    // Steady stream with simultaneous push and pop.
    for (int k = 0; k < 20; k++) begin rand_req(1); step("stream"); end
    set_req(0, 0, 0, 0);
    repeat (4) step("stream");

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      stall = ($urandom_range(0, 3) == 0);
      rand_req($urandom_range(0, 3) != 0);
      step("rand");
    end
    stall = 1'b0; set_req(0, 0, 0, 0);
    repeat (8) step("drain");
    check_table("rand");

    // Drop counter saturation under a permanent stall.
    stall = 1'b1;
    for (int k = 0; k < 270; k++) begin rand_req(1); step("dsat"); end
    chk("dsat.cap", 32'(drop_cnt), 255);
    stall = 1'b0; set_req(0, 0, 0, 0);
    repeat (6) step("dsat");

    // Mid-run reset with three entries pending.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin rand_req(1); step("mr"); end
    set_req(0, 0, 0, 0);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("mr.async");
    @(posedge clk); #1;
    reset = 1'b0; stall = 1'b0;
    for (int k = 0; k < 24; k++) step("resweep");
    check_table("resweep");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bpred_update_sched.md
# bpred_update_sched

Write-port controller for the branch predictor's bimodal counter table. It owns the table's single write port. After every reset it clears the whole table to a known state. It then accepts execute-stage update requests, computes the new 2-bit saturating counter value, buffers the result in a small FIFO, and drains one write per cycle unless the front end stalls. It sits between the execute-stage update signals and the bimodal table memory, which has a separate read/lookup port.

## Interface
Parameters:
- IDX_W, 12: table index width; the table holds 2^IDX_W entries.
- FIFO_DEPTH, 4: number of update FIFO entries; must be a power of two, ≥ 2.
- INIT_CTR, 2'b01: counter value written by the reset sweep (weakly not-taken).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- up_valid  in  1  update request from execute.
- up_index  in  IDX_W  table index of the resolved branch.
- up_old_ctr  in  2  counter value read at predict time (carried in branch meta).
- up_dir  in  1  resolved direction; 1 = taken.
- up_ready  out  1  request is accepted this cycle when up_valid & up_ready.
- stall  in  1  front-end stall (soin_bpredictor_stall); holds the FIFO drain.
- mem_wren  out  1  table write enable, registered.
- mem_wraddr  out  IDX_W  table write address, registered.
- mem_wdata  out  2  table write data, registered.
- init_busy  out  1  high while the reset sweep is in progress.
- pending  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_cnt  out  8  saturating count of requests with up_valid & ~up_ready.

## Operation
- FSM states: INIT and RUN. Reset forces INIT.
- Reset values: sweep_addr=0, FIFO empty, mem_wren=0, mem_wraddr=0, mem_wdata=0, drop_cnt=0, pending=0.
- INIT:
  - Each cycle registers mem_wren=1, mem_wraddr=sweep_addr, mem_wdata=INIT_CTR, then increments sweep_addr.
  - The sweep ignores stall.
  - After the cycle that registers address 2^IDX_W−1, the FSM moves to RUN.
  - init_busy=1 and up_ready=0 throughout INIT.
- RUN:
  - up_ready = ~full.
  - On accept, the entry {up_index, new_ctr} is pushed.
  - new_ctr for taken: old+1, saturating at 3. For not-taken: old−1, saturating at 0. No wraparound.
  - When the FIFO is non-empty and ~stall, the head is popped and registered onto the mem_* outputs with mem_wren=1. Otherwise the next mem_wren=0; mem_wraddr and mem_wdata hold their last values.
- Push and pop may occur in the same cycle.
  - Occupancy is unchanged.
  - The pushed entry is never popped in its own cycle (no bypass).
  - up_ready depends only on the registered full flag, so a full FIFO never accepts, even when popping that cycle.
- Duplicate indices are not merged. Writes reach the table in request order, so the last write to an index wins.
- drop_cnt increments on any cycle with up_valid & ~up_ready, in INIT or RUN. It saturates at 255.
- A reset asserted mid-operation discards FIFO contents and any partial sweep; the sweep restarts at address 0.

## Timing
- Sweep length: exactly 2^IDX_W cycles of mem_wren=1, beginning on the first rising edge after reset deasserts. up_ready first rises the cycle after the last sweep write is registered.
- Update latency with an empty FIFO and no stall:
  - Accept at edge N.
  - mem_wren=1 is registered at edge N+1.
  - The table commits at edge N+2.
- Each stall cycle adds one cycle per blocked pop.
- Sustained throughput is one update per cycle with no stall.

## Structure
- Shared package bpred_pkg holds:
  - the state enum (INIT, RUN);
  - the 2-bit counter width constant;
  - function sat_ctr_update(old, dir).
- One sub-module: bpred_upd_fifo, a synchronous FIFO.
  - Parameterised width and depth.
  - Push, pop, full, empty and count signals.
  - Same clock and asynchronous reset.
- Top-level contents: the FSM, the sweep counter, output registers, and drop_cnt. Target size is roughly 150–250 lines.

## Test plan
- Reset sweep, IDX_W=4: deassert reset → exactly 16 consecutive cycles of mem_wren=1 with addresses 0..15 and data 2'b01, then init_busy=0 and up_ready=1.
- Saturation arithmetic: in RUN, send (idx 5, old 3, taken), (idx 6, old 0, not-taken), (idx 7, old 1, taken) → writes (5,3), (6,0), (7,2), in order, each 2 cycles after its accept edge.
- Backpressure: assert stall and send 6 back-to-back requests with FIFO_DEPTH=4 → 4 accepted, up_ready=0 thereafter, drop_cnt=2. Release stall → 4 writes on 4 consecutive cycles, then pending=0.
- Simultaneous push/pop: keep a steady valid stream with stall=0 → pending stays constant, every request is written, drop_cnt=0.
- Requests during INIT: pulse up_valid 3 times mid-sweep → no extra writes occur, the sweep is unaffected, drop_cnt=3.
- Mid-run reset: with 3 entries pending, assert reset asynchronously between edges → mem_wren=0, pending=0 and drop_cnt=0 immediately. After release, the sweep restarts at address 0 and no stale entries are written.
